// File: rtl/dvb_s2_cfg_commit_seq.sv
// Atomic DVB-S2 modulator config commit sequencer with power-up datapath reset.
// Optional watchdog on ARMED/DRAIN: define DVB_S2_CFG_COMMIT_TIMEOUT_EN.
module dvb_s2_cfg_commit_seq #(
    parameter int unsigned          CFG_WIDTH       = 50,
    parameter logic [CFG_WIDTH-1:0] RESET_CFG       = CFG_WIDTH'(50'h0_09C4_2420_E006),
    parameter int unsigned          RST_HOLD_CYCLES = 16,
    parameter int unsigned          TIMEOUT_CYCLES  = 65536
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CFG_WIDTH-1:0] staged_cfg,
    input  logic                 commit_req,
    input  logic                 commit_force,
    input  logic                 frame_start,
    input  logic                 dp_idle,
    output logic [CFG_WIDTH-1:0] active_cfg,
    output logic                 dp_rst_n,
    output logic                 busy,
    output logic                 commit_done,
    output logic [15:0]          commit_count,
    output logic                 timeout_flag
);

    localparam int unsigned HOLD_W = 8;
    localparam int unsigned WD_W   = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t               state;
    logic [CFG_WIDTH-1:0] pending;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 requeue;
    logic                 por_load;
    logic                 por_pass;

    logic                 wd_expire_c;
    logic                 start_c;
    logic                 hold_go_c;
    logic [CFG_WIDTH-1:0] hold_cfg_c;

    // Accept/transition decode; a commit_req racing a forced ARMED exit still wins.
    always_comb begin
        start_c    = (state == ST_IDLE) && (commit_req || requeue);
        hold_go_c  = 1'b0;
        hold_cfg_c = pending;
        case (state)
            ST_ARMED: begin
                hold_go_c = commit_force || wd_expire_c;
                if (commit_req) begin
                    hold_cfg_c = staged_cfg;
                end
            end
            ST_DRAIN: hold_go_c = commit_force || dp_idle || wd_expire_c;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_HOLD;
            pending      <= RESET_CFG;
            active_cfg   <= RESET_CFG;
            hold_cnt     <= '0;
            requeue      <= 1'b0;
            por_load     <= 1'b1;
            por_pass     <= 1'b1;
            dp_rst_n     <= 1'b0;
            busy         <= 1'b1;
            commit_done  <= 1'b0;
            commit_count <= '0;
        end else begin
            commit_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        pending <= staged_cfg;
                        requeue <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (commit_req) begin
                        pending <= staged_cfg;
                    end
                    if (!hold_go_c && frame_start) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (commit_req) begin
                        requeue <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (commit_req) begin
                        requeue <= 1'b1;
                    end
                    // Power-up pass loads the window on the first cycle out of reset.
                    if (por_load) begin
                        hold_cnt <= HOLD_W'(RST_HOLD_CYCLES - 1);
                        por_load <= 1'b0;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else begin
                        state    <= ST_IDLE;
                        dp_rst_n <= 1'b1;
                        busy     <= 1'b0;
                        por_pass <= 1'b0;
                        if (!por_pass) begin
                            commit_done  <= 1'b1;
                            commit_count <= commit_count + 16'd1;
                        end
                    end
                end
            endcase

            // HOLD entry: config and datapath reset change on the same edge.
            if (hold_go_c) begin
                state      <= ST_HOLD;
                active_cfg <= hold_cfg_c;
                dp_rst_n   <= 1'b0;
                hold_cnt   <= HOLD_W'(RST_HOLD_CYCLES - 1);
            end
        end
    end

`ifdef DVB_S2_CFG_COMMIT_TIMEOUT_EN
    logic [WD_W-1:0] wd_cnt;

    assign wd_expire_c = ((state == ST_ARMED) || (state == ST_DRAIN)) &&
                         (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts on each accepted commit; flag is sticky until then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else if (start_c) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else if ((state == ST_ARMED) || (state == ST_DRAIN)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_expire_c) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    assign wd_expire_c  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_dvb_s2_cfg_commit_seq.sv
// Directed bench for dvb_s2_cfg_commit_seq: vector table plus multi-cycle sequences.
module tb_dvb_s2_cfg_commit_seq;

    localparam logic [49:0] RST_CFG = 50'h0_09C4_2420_E006;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [49:0] staged_cfg;
    logic        commit_req, commit_force, frame_start, dp_idle;
    logic [49:0] active_cfg;
    logic        dp_rst_n, busy, commit_done, timeout_flag;
    logic [15:0] commit_count;

    always #5 clk = ~clk;

    dvb_s2_cfg_commit_seq #(
        .CFG_WIDTH(50),
        .RESET_CFG(RST_CFG),
        .RST_HOLD_CYCLES(16),
        .TIMEOUT_CYCLES(64)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .staged_cfg(staged_cfg),
        .commit_req(commit_req),
        .commit_force(commit_force),
        .frame_start(frame_start),
        .dp_idle(dp_idle),
        .active_cfg(active_cfg),
        .dp_rst_n(dp_rst_n),
        .busy(busy),
        .commit_done(commit_done),
        .commit_count(commit_count),
        .timeout_flag(timeout_flag)
    );

    typedef struct {
        logic [49:0] cfg;
        logic [49:0] cfg2;
        int          req2_at;
        logic        frc;
        int          fs_at;
        int          idle_at;
        int          exp_h;
        int          exp_done;
    } vec_t;

    vec_t        vecs[5];
    int          total = 0;
    int          bad = 0;
    logic [49:0] exp_active;
    int          exp_count;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [49:0] mk_cfg(input logic [1:0] m, input logic [3:0] l,
                                           input logic [31:0] b);
        logic [49:0] r;
        r        = RST_CFG;
        r[1:0]   = m;
        r[5:2]   = l;
        r[47:16] = b;
        return r;
    endfunction

    task automatic power_up_check(input string tag);
        int lows = 0;
        int seen = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (commit_done) seen = 1;
            if (!dp_rst_n) lows++;
            else break;
        end
        check({tag, "_low_cycles"}, 64'(lows), 64'd16);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cfg"}, 64'(active_cfg), 64'(RST_CFG));
        check({tag, "_count"}, 64'(commit_count), 64'd0);
        check({tag, "_no_done"}, 64'(seen), 64'd0);
    endtask

    task automatic finish_commit(input string name);
        int got = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (commit_done) begin
                got = 1;
                break;
            end
        end
        check(name, 64'(got), 64'd1);
    endtask

    initial begin
        logic [49:0] want, c_a, c_b, c_t, c_u, c_v;
        int h_obs, d_obs, chg_obs, nd, seen_busy;

        rst_n = 1'b0; staged_cfg = RST_CFG;
        commit_req = 1'b0; commit_force = 1'b0; frame_start = 1'b0; dp_idle = 1'b0;
        repeat (3) tick();
        check("rst_dp_rst_n", 64'(dp_rst_n), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_done", 64'(commit_done), 64'd0);
        check("rst_cfg", 64'(active_cfg), 64'(RST_CFG));
        check("rst_count", 64'(commit_count), 64'd0);
        check("rst_timeout", 64'(timeout_flag), 64'd0);
        power_up_check("pwrup");
        exp_active = RST_CFG;
        exp_count  = 0;

        // Cycle c = posedge index counted from the commit_req sampling edge.
        vecs[0] = '{cfg: mk_cfg(2'd1, 4'd9, RST_CFG[47:16]), cfg2: '0, req2_at: -1, frc: 1'b0,
                    fs_at: 10, idle_at: 15, exp_h: 15, exp_done: 31};
        vecs[1] = '{cfg: mk_cfg(2'd3, 4'd2, 32'd7000), cfg2: '0, req2_at: -1, frc: 1'b1,
                    fs_at: 99, idle_at: 99, exp_h: 1, exp_done: 17};
        vecs[2] = '{cfg: mk_cfg(2'd0, 4'd4, 32'd2500), cfg2: mk_cfg(2'd0, 4'd4, 32'd1000),
                    req2_at: 3, frc: 1'b0, fs_at: 8, idle_at: 10, exp_h: 10, exp_done: 26};
        vecs[3] = '{cfg: mk_cfg(2'd2, 4'd11, 32'd4000), cfg2: '0, req2_at: -1, frc: 1'b0,
                    fs_at: 4, idle_at: 4, exp_h: 5, exp_done: 21};
        vecs[4] = '{cfg: mk_cfg(2'd1, 4'd6, 32'd6000), cfg2: '0, req2_at: -1, frc: 1'b0,
                    fs_at: 6, idle_at: 0, exp_h: 7, exp_done: 23};

        foreach (vecs[k]) begin
            want    = (vecs[k].req2_at >= 0) ? vecs[k].cfg2 : vecs[k].cfg;
            h_obs   = -1; d_obs = -1; chg_obs = -1; nd = 0;
            for (int c = 0; c < 60; c++) begin
                commit_req   = (c == 0) || (c == vecs[k].req2_at);
                staged_cfg   = (vecs[k].req2_at >= 0 && c >= vecs[k].req2_at) ?
                               vecs[k].cfg2 : vecs[k].cfg;
                commit_force = vecs[k].frc;
                frame_start  = !vecs[k].frc && (c == vecs[k].fs_at);
                dp_idle      = (c >= vecs[k].idle_at) && (h_obs < 0);
                tick();
                if (c == 0) check($sformatf("v%0d_busy_rise", k), 64'(busy), 64'd1);
                if (!dp_rst_n && h_obs < 0) h_obs = c;
                if (active_cfg !== exp_active && chg_obs < 0) chg_obs = c;
                if (commit_done) begin
                    nd++;
                    if (d_obs < 0) d_obs = c;
                end
            end
            commit_req = 1'b0; commit_force = 1'b0; frame_start = 1'b0; dp_idle = 1'b0;
            exp_count++;
            check($sformatf("v%0d_hold_edge", k), 64'(h_obs), 64'(vecs[k].exp_h));
            check($sformatf("v%0d_cfg_edge", k), 64'(chg_obs), 64'(vecs[k].exp_h));
            check($sformatf("v%0d_done_edge", k), 64'(d_obs), 64'(vecs[k].exp_done));
            check($sformatf("v%0d_done_cnt", k), 64'(nd), 64'd1);
            check($sformatf("v%0d_cfg", k), 64'(active_cfg), 64'(want));
            check($sformatf("v%0d_count", k), 64'(commit_count), 64'(exp_count));
            check($sformatf("v%0d_idle", k), 64'({busy, dp_rst_n}), 64'b01);
            exp_active = want;
        end

        // frame_start/dp_idle alone never start a commit
        seen_busy = 0;
        frame_start = 1'b1; dp_idle = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy) seen_busy = 1;
        end
        frame_start = 1'b0; dp_idle = 1'b0;
        check("idle_ignore_busy", 64'(seen_busy), 64'd0);
        check("idle_ignore_cfg", 64'(active_cfg), 64'(exp_active));

        // commit_req during DRAIN requeues a second commit with the later staged value
        c_a = mk_cfg(2'd2, 4'd5, 32'd3000);
        c_b = mk_cfg(2'd1, 4'd3, 32'd5000);
        nd  = 0;
        for (int c = 0; c < 60; c++) begin
            commit_req  = (c == 0) || (c == 5);
            staged_cfg  = (c < 5) ? c_a : c_b;
            frame_start = (c == 3) || (c == 30);
            dp_idle     = (c >= 7 && c < 10) || (c >= 32 && c < 35);
            tick();
            if (commit_done) nd++;
            if (c == 6)  check("rq_pre_hold_cfg", 64'(active_cfg), 64'(exp_active));
            if (c == 7)  check("rq_first_cfg", 64'(active_cfg), 64'(c_a));
            if (c == 23) check("rq_done1", 64'({commit_done, busy}), 64'b10);
            if (c == 24) check("rq_rearm", 64'({commit_done, busy}), 64'b01);
            if (c == 31) check("rq_cfg_held", 64'(active_cfg), 64'(c_a));
            if (c == 32) check("rq_second_cfg", 64'(active_cfg), 64'(c_b));
            if (c == 48) check("rq_done2", 64'(commit_done), 64'd1);
        end
        commit_req = 1'b0; frame_start = 1'b0; dp_idle = 1'b0;
        exp_count += 2;
        exp_active = c_b;
        check("rq_done_cnt", 64'(nd), 64'd2);
        check("rq_count", 64'(commit_count), 64'(exp_count));

        // No frame_start after commit_req: watchdog behaviour
        c_t = mk_cfg(2'd0, 4'd7, 32'd1234);
        c_u = mk_cfg(2'd3, 4'd1, 32'd4321);
        staged_cfg = c_t;
        h_obs = -1; d_obs = -1;
        for (int c = 0; c < 100; c++) begin
            commit_req = (c == 0);
            tick();
            if (!dp_rst_n && h_obs < 0) h_obs = c;
            if (commit_done && d_obs < 0) d_obs = c;
        end
        commit_req = 1'b0;
`ifdef DVB_S2_CFG_COMMIT_TIMEOUT_EN
        exp_count++;
        check("to_hold_edge", 64'(h_obs), 64'd64);
        check("to_done_edge", 64'(d_obs), 64'd80);
        check("to_flag_set", 64'(timeout_flag), 64'd1);
        check("to_cfg", 64'(active_cfg), 64'(c_t));
        staged_cfg = c_u; commit_req = 1'b1; commit_force = 1'b1;
        tick();
        commit_req = 1'b0;
        check("to_flag_clear", 64'(timeout_flag), 64'd0);
        finish_commit("to_second_done");
        commit_force = 1'b0;
        exp_count++;
        exp_active = c_u;
`else
        check("to_stay_armed", 64'({busy, dp_rst_n}), 64'b11);
        check("to_no_hold", 64'(h_obs), 64'hFFFF_FFFF_FFFF_FFFF);
        check("to_flag_zero", 64'(timeout_flag), 64'd0);
        check("to_cfg_unchanged", 64'(active_cfg), 64'(exp_active));
        commit_force = 1'b1;
        finish_commit("to_force_done");
        commit_force = 1'b0;
        exp_count++;
        exp_active = c_t;
`endif
        tick();
        check("to_final_cfg", 64'(active_cfg), 64'(exp_active));
        check("to_final_count", 64'(commit_count), 64'(exp_count));

        // Reset asserted mid-HOLD discards the commit and reruns power-up
        c_v = mk_cfg(2'd2, 4'd12, 32'd9999);
        staged_cfg = c_v; commit_req = 1'b1; commit_force = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (4) tick();
        check("mid_hold_cfg", 64'(active_cfg), 64'(c_v));
        rst_n = 1'b0; commit_force = 1'b0;
        repeat (2) tick();
        check("mid_rst_cfg", 64'(active_cfg), 64'(RST_CFG));
        check("mid_rst_state", 64'({dp_rst_n, busy, commit_done}), 64'b010);
        check("mid_rst_count", 64'(commit_count), 64'd0);
        power_up_check("mid_pwrup");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
